// File: rtl/adc_pkg.sv
// Shared definitions for the ADC sweep reader: FSM state encoding, command
// format helpers and default widths/latencies.
package adc_pkg;

  localparam int DATA_W_DEF   = 16;
  localparam int PIPE_LAT_DEF = 2;
  localparam int CH_MAX_DEF   = 32;

  localparam logic [1:0] CMD_CONVERT = 2'b00;

  typedef enum logic [7:0] {
    IDLE = 8'd0,
    CSLO = 8'd1,
    SHFT = 8'd2,
    CSHI = 8'd3,
    STOR = 8'd4,
    LAST = 8'd5
  } state_t;

  // Frames past the last real channel only flush the ADC pipeline, so they
  // carry a harmless CONVERT(0).
  function automatic logic [15:0] convert_cmd(input logic [7:0] k, input logic [7:0] n_ch);
    logic [5:0] ch;
    ch = (k < n_ch) ? k[5:0] : 6'd0;
    return {CMD_CONVERT, ch, 8'h00};
  endfunction

  function automatic logic [7:0] clamp_ch(input logic [7:0] cnt, input logic [7:0] ch_max);
    if (cnt == 8'd0)   return 8'd1;
    if (cnt > ch_max)  return ch_max;
    return cnt;
  endfunction

endpackage

// File: rtl/adc_read_if.sv
// Command handshake and FIFO-A write port of the ADC sweep reader.
// master = command FSM / FIFO side, slave = adc_read.
interface adc_read_if #(
  parameter int DATA_W = 16
);
  logic              fs_adc_read;
  logic              fd_adc_read;
  logic [7:0]        adc_cnt;
  logic              sweep_abort;
  logic              fifo_full;
  logic              fifo_txen;
  logic [DATA_W-1:0] fifo_txd;

  modport master (
    output fs_adc_read, adc_cnt, fifo_full,
    input  fd_adc_read, sweep_abort, fifo_txen, fifo_txd
  );

  modport slave (
    input  fs_adc_read, adc_cnt, fifo_full,
    output fd_adc_read, sweep_abort, fifo_txen, fifo_txd
  );
endinterface

// File: rtl/spi_frame.sv
// One mode-0 SPI frame: CLK_DIV-cycle SCLK half periods, DATA_W bits MSB
// first through a single shift register (MOSI out of the top, MISO in at the bottom).
module spi_frame #(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 4
) (
  input  logic              sys_clk,
  input  logic              rst_all,
  input  logic              clr,
  input  logic              load,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_word,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic              done,
  output logic [DATA_W-1:0] rx_word
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_W);

  logic              busy;
  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              div_end;
  logic              last_bit;

  assign div_end  = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign last_bit = (bit_cnt == BIT_W'(DATA_W - 1));
  assign done     = busy && !sclk && div_end && last_bit;
  assign mosi     = shreg[DATA_W-1];
  assign rx_word  = shreg;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // sees the pre-edge value of its neighbours.
  always_ff @(posedge sys_clk or posedge rst_all) begin
    if (rst_all) begin
      busy    <= 1'b0;
      sclk    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (clr) begin
      busy    <= 1'b0;
      sclk    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      if (load) shreg <= tx_word;
      if (start) begin
        busy    <= 1'b1;
        sclk    <= 1'b1;
        div_cnt <= '0;
        bit_cnt <= '0;
      end else if (busy) begin
        if (!div_end) begin
          div_cnt <= div_cnt + 1'b1;
        end else begin
          div_cnt <= '0;
          if (sclk) begin
            // Last cycle of the high phase: capture MISO and advance MOSI together.
            sclk  <= 1'b0;
            shreg <= {shreg[DATA_W-2:0], miso};
          end else if (last_bit) begin
            busy <= 1'b0;
          end else begin
            sclk    <= 1'b1;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/adc_read.sv
// ADC sweep reader: answers the fs/fd_adc_read handshake by converting n_ch
// channels on a pipelined SPI ADC and writing each sample to FIFO-A.
// Build option: define ADC_DUMMY_EN to store the pattern {sample_idx, 8'hA5}.
module adc_read
  import adc_pkg::*;
#(
  parameter int CH_MAX   = CH_MAX_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int CLK_DIV  = 4,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic       sys_clk,
  input  logic       rst_all,
  adc_read_if.slave  bus,
  output logic       spi_cs_n,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam int TMR_W = $clog2(3 * CLK_DIV) + 1;
  localparam logic [TMR_W-1:0] CS_LO_END = TMR_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0] CS_HOLD   = TMR_W'(CLK_DIV);
  localparam logic [TMR_W-1:0] CS_HI_END = TMR_W'(3 * CLK_DIV - 1);

  state_t            state_q, state_d;
  logic [TMR_W-1:0]  tmr_q;
  logic [7:0]        n_ch_q, frame_q, frame_d, stored_q, frames_total;
  logic              fs_q, start_edge, abort, load, start, wr, frame_done;
  logic [DATA_W-1:0] tx_word, rx_word, sample;
  logic              fd_q, abort_q, txen_q;
  logic [DATA_W-1:0] txd_q;

  assign start_edge   = bus.fs_adc_read && !fs_q;
  assign frames_total = n_ch_q + 8'(PIPE_LAT);
  assign tx_word      = DATA_W'(convert_cmd(frame_d, n_ch_q));

`ifdef ADC_DUMMY_EN
  assign sample = DATA_W'({stored_q, 8'hA5});
`else
  assign sample = rx_word;
`endif

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    load    = 1'b0;
    start   = 1'b0;
    wr      = 1'b0;
    abort   = !bus.fs_adc_read && (state_q inside {CSLO, SHFT, CSHI, STOR});
    case (state_q)
      IDLE: if (start_edge) begin
        state_d = CSLO;
        frame_d = 8'd0;
        load    = 1'b1;
      end
      CSLO: if (tmr_q == CS_LO_END) begin
        state_d = SHFT;
        start   = 1'b1;
      end
      SHFT: if (frame_done) state_d = CSHI;
      CSHI: if (tmr_q == CS_HI_END) begin
        frame_d = frame_q + 8'd1;
        if (frame_q >= 8'(PIPE_LAT)) begin
          state_d = STOR;
        end else begin
          state_d = CSLO;
          load    = 1'b1;
        end
      end
      STOR: if (!bus.fifo_full) begin
        wr = 1'b1;
        if (frame_q < frames_total) begin
          state_d = CSLO;
          load    = 1'b1;
        end else begin
          state_d = LAST;
        end
      end
      LAST: if (!bus.fs_adc_read) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      frame_d = frame_q;
      load    = 1'b0;
      start   = 1'b0;
      wr      = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or posedge rst_all) begin
    if (rst_all) begin
      state_q  <= IDLE;
      tmr_q    <= '0;
      n_ch_q   <= 8'd1;
      frame_q  <= 8'd0;
      stored_q <= 8'd0;
      // NOTE: reset the edge detector to 1 so a start level held through reset
      // needs a fresh rising edge before a sweep begins.
      fs_q     <= 1'b1;
      fd_q     <= 1'b0;
      abort_q  <= 1'b0;
      txen_q   <= 1'b0;
      txd_q    <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= (state_d != state_q) ? '0 : tmr_q + 1'b1;
      frame_q <= frame_d;
      fs_q    <= bus.fs_adc_read;
      if (state_q == IDLE && start_edge) begin
        n_ch_q   <= clamp_ch(bus.adc_cnt, 8'(CH_MAX));
        stored_q <= 8'd0;
      end else if (wr) begin
        stored_q <= stored_q + 8'd1;
      end
      if (wr) txd_q <= sample;
      txen_q  <= wr;
      fd_q    <= (state_d == LAST);
      abort_q <= abort;
    end
  end

  // Chip select decodes straight from registered state, so it drops back to
  // idle in the same cycle as an abort or reset.
  assign spi_cs_n = !((state_q == CSLO) || (state_q == SHFT) ||
                      (state_q == CSHI && tmr_q < CS_HOLD));

  assign bus.fd_adc_read = fd_q;
  assign bus.sweep_abort = abort_q;
  assign bus.fifo_txen   = txen_q;
  assign bus.fifo_txd    = txd_q;

  spi_frame #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV)
  ) u_spi_frame (
    .sys_clk (sys_clk),
    .rst_all (rst_all),
    .clr     (abort),
    .load    (load),
    .start   (start),
    .tx_word (tx_word),
    .miso    (spi_miso),
    .sclk    (spi_sclk),
    .mosi    (spi_mosi),
    .done    (frame_done),
    .rx_word (rx_word)
  );

endmodule

// File: tb/tb_adc_read.sv
// Directed bench for adc_read: a pipelined ADC model answers each command two
// frames late with 16'h1000+channel; FIFO writes are collected and compared.
module tb_adc_read;

  localparam int CLK_DIV = 4;

  logic sys_clk = 1'b0;
  logic rst_all;
  logic spi_cs_n, spi_sclk, spi_mosi, spi_miso;

  adc_read_if #(.DATA_W(16)) bus ();

  adc_read #(.CLK_DIV(CLK_DIV)) dut (
    .sys_clk  (sys_clk),
    .rst_all  (rst_all),
    .bus      (bus),
    .spi_cs_n (spi_cs_n),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---- pipelined ADC model ----
  logic [15:0] cmd_hist [64];
  logic [15:0] resp, rx_cmd;
  int fidx = 0, bitn = 0, cs_falls = 0;

  always @(negedge spi_cs_n) begin
    cs_falls++;
    bitn = 0;
    if (fidx >= 2 && fidx < 66)
      resp = (cmd_hist[fidx-2][15:14] == 2'b00) ? 16'h1000 + {10'd0, cmd_hist[fidx-2][13:8]} : 16'hFFFF;
    else
      resp = 16'hBEEF;
    spi_miso = resp[15];
  end
  always @(posedge spi_sclk) rx_cmd = {rx_cmd[14:0], spi_mosi};
  always @(negedge spi_sclk) begin
    bitn++;
    if (bitn < 16) spi_miso = resp[15-bitn];
  end
  always @(posedge spi_cs_n) if (fidx < 64) begin
    cmd_hist[fidx] = rx_cmd;
    fidx++;
  end

  // ---- output monitor ----
  logic [15:0] got_q [$];
  int abort_cnt = 0;
  always @(negedge sys_clk) begin
    if (bus.fifo_txen === 1'b1) got_q.push_back(bus.fifo_txd);
    if (bus.sweep_abort === 1'b1) abort_cnt++;
  end

  function automatic logic [15:0] exp_word(input int i);
`ifdef ADC_DUMMY_EN
    logic [7:0] lo;
    lo = 8'(i);
    return {lo, 8'hA5};
`else
    return 16'h1000 + 16'(i);
`endif
  endfunction

  task automatic model_clear();
    fidx = 0;
    abort_cnt = 0;
    rx_cmd = 16'h0;
    got_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs_n"},  spi_cs_n, 1);
    check({tag, "_sclk"},  spi_sclk, 0);
    check({tag, "_mosi"},  spi_mosi, 0);
    check({tag, "_fd"},    bus.fd_adc_read, 0);
    check({tag, "_txen"},  bus.fifo_txen, 0);
    check({tag, "_txd"},   bus.fifo_txd, 0);
    check({tag, "_abort"}, bus.sweep_abort, 0);
  endtask

  task automatic wait_fd(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge sys_clk);
      if (bus.fd_adc_read === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_frames(input int n, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge sys_clk);
      if (fidx >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_sclk_high(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge sys_clk);
      if (spi_sclk === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_writes(input string tag, input int n);
    logic [15:0] v;
    check({tag, "_nwr"}, got_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < got_q.size()) v = got_q[i];
      else v = 16'hxxxx;
      check($sformatf("%s_d%0d", tag, i), v, exp_word(i));
    end
  endtask

  // Full sweep with handshake completion; n = expected number of samples.
  task automatic run_sweep(input string tag, input logic [7:0] cnt, input int n);
    bit ok;
    @(negedge sys_clk);
    model_clear();
    bus.adc_cnt = cnt;
    bus.fs_adc_read = 1'b1;
    wait_fd(8000, ok);
    check({tag, "_done"}, ok, 1);
    repeat (5) @(negedge sys_clk);
    check({tag, "_fd_hold"}, bus.fd_adc_read, 1);
    bus.fs_adc_read = 1'b0;
    #1 check({tag, "_fd_reg"}, bus.fd_adc_read, 1);
    @(negedge sys_clk);
    check({tag, "_fd_clr"}, bus.fd_adc_read, 0);
    check({tag, "_frames"}, fidx, n + 2);
    check({tag, "_abort"}, abort_cnt, 0);
    check_writes(tag, n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int viol, base;
    bus.fs_adc_read = 1'b0;
    bus.adc_cnt     = 8'd0;
    bus.fifo_full   = 1'b0;
    spi_miso        = 1'b0;
    rst_all         = 1'b1;
    repeat (3) @(negedge sys_clk);
    check_reset_outputs("rst");
    rst_all = 1'b0;
    repeat (3) @(negedge sys_clk);

    // Main sweeps, including clamp boundaries.
    run_sweep("ch4", 8'd4, 4);
    run_sweep("ch0", 8'd0, 1);
    run_sweep("ch200", 8'd200, 32);

    // FIFO full stall at the first STOR.
    @(negedge sys_clk);
    model_clear();
    bus.fifo_full = 1'b1;
    bus.adc_cnt = 8'd4;
    bus.fs_adc_read = 1'b1;
    wait_frames(3, 2000, ok);
    check("full_reach", ok, 1);
    repeat (20) @(negedge sys_clk);
    viol = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge sys_clk);
      if (bus.fifo_txen !== 1'b0 || spi_sclk !== 1'b0 || spi_cs_n !== 1'b1) viol++;
    end
    check("full_stall_idle", viol, 0);
    check("full_stall_nwr", got_q.size(), 0);
    check("full_stall_frames", fidx, 3);
    bus.fifo_full = 1'b0;
    @(negedge sys_clk);
    check("full_wr_txen", bus.fifo_txen, 1);
    check("full_wr_txd", bus.fifo_txd, exp_word(0));
    wait_fd(4000, ok);
    check("full_done", ok, 1);
    bus.fs_adc_read = 1'b0;
    @(negedge sys_clk);
    check("full_frames", fidx, 6);
    check_writes("full", 4);

    // Abort mid-SHFT of frame 2.
    @(negedge sys_clk);
    model_clear();
    bus.adc_cnt = 8'd4;
    bus.fs_adc_read = 1'b1;
    wait_frames(2, 2000, ok);
    check("abort_reach", ok, 1);
    wait_sclk_high(100, ok);
    check("abort_shft", ok, 1);
    repeat (20) @(negedge sys_clk);
    bus.fs_adc_read = 1'b0;
    @(negedge sys_clk);
    check("abort_cs_n", spi_cs_n, 1);
    check("abort_sclk", spi_sclk, 0);
    viol = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge sys_clk);
      if (bus.fd_adc_read !== 1'b0 || spi_cs_n !== 1'b1) viol++;
    end
    check("abort_quiet", viol, 0);
    check("abort_pulses", abort_cnt, 1);
    check("abort_nwr", got_q.size(), 0);
    run_sweep("post_abort", 8'd2, 2);

    // Reset mid-frame with start held high.
    @(negedge sys_clk);
    model_clear();
    bus.adc_cnt = 8'd4;
    bus.fs_adc_read = 1'b1;
    wait_frames(1, 2000, ok);
    check("rst_reach", ok, 1);
    wait_sclk_high(100, ok);
    repeat (10) @(negedge sys_clk);
    rst_all = 1'b1;
    #1 check_reset_outputs("rst_mid");
    @(negedge sys_clk);
    rst_all = 1'b0;
    base = cs_falls;
    repeat (300) @(negedge sys_clk);
    check("rst_no_restart", cs_falls - base, 0);
    check("rst_nwr", got_q.size(), 0);
    check("rst_fd", bus.fd_adc_read, 0);
    bus.fs_adc_read = 1'b0;
    repeat (2) @(negedge sys_clk);
    run_sweep("post_rst", 8'd1, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/adc_read.md
Name: adc_read

Overview:
- Responder side of the `fs_adc_read` / `fd_adc_read` handshake issued by the system command FSM.
- On a start request it runs an SPI master through one conversion sweep of `adc_cnt` channels on a pipelined-SPI ADC (result returns 2 frames after its command).
- Writes each 16-bit sample into the ADC data FIFO, then raises done.
- Sits between the command FSM, the ADC pins and the FIFO-A write port.

Parameters:
- CH_MAX, 32, maximum channels per sweep; `adc_cnt` is clamped to this.
- DATA_W, 16, SPI frame / sample width.
- CLK_DIV, 4, sys_clk cycles per SCLK half-period (≥2).
- PIPE_LAT, 2, frames of ADC result latency; this many leading results are discarded.

Ports:
- sys_clk  in  1  system clock
- rst_all  in  1  asynchronous, active-high reset
- fs_adc_read  in  1  start level from command FSM
- fd_adc_read  out  1  done level to command FSM
- adc_cnt  in  8  channels to convert this sweep
- spi_cs_n  out  1  ADC chip select, active low
- spi_sclk  out  1  SPI clock, mode 0
- spi_mosi  out  1  command bit out
- spi_miso  in  1  result bit in
- fifo_full  in  1  FIFO-A full
- fifo_txen  out  1  FIFO-A write strobe, 1 cycle
- fifo_txd  out  DATA_W  FIFO-A write data
- sweep_abort  out  1  1-cycle pulse when a sweep is aborted

Behaviour:
- Clock is sys_clk; reset is rst_all, asynchronous, active-high.
- Reset values: spi_cs_n=1, spi_sclk=0, spi_mosi=0, fd_adc_read=0, fifo_txen=0, fifo_txd=0, sweep_abort=0, state=IDLE.
- Rising edge of `fs_adc_read` is detected against a registered copy.
- `n_ch` is latched at the start edge: `adc_cnt`; 0 maps to 1; values above CH_MAX map to CH_MAX.
- Total frames per sweep = n_ch + PIPE_LAT.
- Command word for frame k:
  - k < n_ch: CONVERT(ch = k) = {2'b00, k[5:0], 8'h00}.
  - k ≥ n_ch: dummy CONVERT(0).
- State machine:
  - IDLE: start edge → CSLO; latch n_ch; frame counter=0; stored-sample counter=0.
  - CSLO: cs_n=0 for CLK_DIV cycles; MOSI presents the command MSB → SHFT.
  - SHFT: DATA_W SCLK periods.
    - SCLK high for CLK_DIV cycles, then low for CLK_DIV cycles.
    - MISO is sampled on the last sys_clk of each SCLK high phase, MSB first.
    - MOSI updates on each SCLK falling edge.
    - After the last bit → CSHI.
  - CSHI: SCLK=0; cs_n=0 for CLK_DIV cycles, then cs_n=1 for 2·CLK_DIV cycles. Then:
    - frame ≥ PIPE_LAT → STOR.
    - otherwise, more frames remain → CSLO.
  - STOR: wait while fifo_full=1 (stall, no write, SPI idle). When fifo_full=0: fifo_txen=1 for 1 cycle with fifo_txd = shifted word. Then:
    - frames remain → CSLO.
    - otherwise → LAST.
  - LAST: fd_adc_read=1 held until `fs_adc_read`=0, then → IDLE with fd_adc_read=0 on the next cycle.
- Latency (CLK_DIV=4): one frame = 4 + 16·8 + 4 + 8 = 144 cycles plus a 1-cycle STOR when the FIFO is not full.
- Exactly n_ch FIFO writes occur per completed sweep, in channel order 0..n_ch-1.
- Abort: `fs_adc_read`=0 in any state other than IDLE or LAST:
  - next cycle → IDLE; cs_n=1; sclk=0.
  - sweep_abort pulses once; no fd; no further FIFO writes.
- Start edge while not in IDLE is ignored.
- Start held high after LAST→IDLE does not retrigger; a new rising edge is required.
- rst_all mid-frame: outputs go to reset values immediately; the partial word is dropped.
- fifo_full asserting during SHFT has no effect until STOR.

Optional Feature:
- Macro: ADC_DUMMY_EN.
- Defined: the sampled MISO word is replaced by the test pattern {frame_lo[7:0], 8'hA5}, where frame_lo is the frame counter of the command that produced the sample (frame − PIPE_LAT). The SPI pins still toggle normally. Used for bring-up without an ADC.
- Undefined: the real MISO data is stored.

Decomposition:
- Shared package `adc_pkg`:
  - state localparams IDLE/CSLO/SHFT/CSHI/STOR/LAST (8-bit, matching the codebase's state-width style);
  - CMD_CONVERT prefix 2'b00;
  - DATA_W default;
  - PIPE_LAT default.
- One sub-module, `spi_frame`: a CLK_DIV divider plus a DATA_W shift register with start/done.
- `adc_read` keeps the sweep FSM, counters, FIFO write and handshake.

Test Plan:
- adc_cnt=4, CLK_DIV=4, MISO model returns 16'h1000+ch two frames late → 6 CS frames, 4 fifo_txen pulses with data 1000,1001,1002,1003; fd_adc_read=1 until fs drops, then 0 one cycle later.
- adc_cnt=0 → exactly 1 FIFO write (ch 0), 3 frames; adc_cnt=200 → 32 writes (CH_MAX).
- fifo_full held high for 50 cycles at the first STOR → no write during the stall, SCLK idle, CS high; the write occurs the cycle after full drops; total writes unchanged.
- fs_adc_read dropped mid-SHFT of frame 2 → cs_n=1 next cycle, one sweep_abort pulse, no fd, no more writes; a later start edge runs a clean sweep.
- rst_all pulsed mid-frame → all outputs at reset values the same cycle; fs held high does not restart without a new edge.
- ADC_DUMMY_EN defined, adc_cnt=3 → FIFO data 00A5, 01A5, 02A5.
